lcd_write_arbiter: RTL and testbench



---
 rtl/lcd_write_arbiter_if.sv | 28 ++
 rtl/lcd_write_arbiter.sv | 139 +++++++++++++
 tb/tb_lcd_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_arbiter_if.sv
// Requester and LCD-controller signal bundle for lcd_write_arbiter.
// slave: arbiter side; master: requesters plus controller side.
interface lcd_write_arbiter_if;
    logic       iREQ0;
    logic       iREQ1;
    logic [8:0] iDATA0;
    logic [8:0] iDATA1;
    logic       iLOCK0;
    logic       iLOCK1;
    logic       oACK0;
    logic       oACK1;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_START;
    logic       iLCD_DONE;
    logic       oGNT;
    logic       oBUSY;

    modport slave (
        input  iREQ0, iREQ1, iDATA0, iDATA1, iLOCK0, iLOCK1, iLCD_DONE,
        output oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_START, oGNT, oBUSY
    );

    modport master (
        output iREQ0, iREQ1, iDATA0, iDATA1, iLOCK0, iLOCK1, iLCD_DONE,
        input  oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_START, oGNT, oBUSY
    );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Two-requester arbiter/sequencer for one character-LCD controller.
// LCD_ARB_ROUND_ROBIN_EN: alternate tie priority; else requester 0 wins ties.
module lcd_write_arbiter #(
    parameter int unsigned DLY_CYCLES = 262142,
    parameter int unsigned DLY_W      = 18
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    lcd_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_DONE, DELAY, ACK} state_e;

    localparam logic [DLY_W-1:0] LAST = DLY_W'(DLY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic             start_q, start_d;
    logic [8:0]       word_q, word_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic [1:0] req;
    logic [1:0] lock_in;
    logic       locked;
    logic       have_win;
    logic       win;

    assign req     = {bus.iREQ1, bus.iREQ0};
    assign lock_in = {bus.iLOCK1, bus.iLOCK0};

    // A held lock restricts candidates to the current owner.
    always_comb begin
        locked   = lock_q && lock_in[gnt_q];
        have_win = 1'b0;
        win      = 1'b0;
        if (locked) begin
            have_win = req[gnt_q];
            win      = gnt_q;
        end else begin
            unique case (req)
                2'b01: begin have_win = 1'b1; win = 1'b0;  end
                2'b10: begin have_win = 1'b1; win = 1'b1;  end
                2'b11: begin have_win = 1'b1; win = ptr_q; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        start_d = start_q;
        word_d  = word_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                lock_d = locked;
                cnt_d  = '0;
                if (have_win) begin
                    gnt_d   = win;
                    word_d  = win ? bus.iDATA1 : bus.iDATA0;
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.iLCD_DONE) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    if (DLY_CYCLES == 0) begin
                        state_d = ACK;
                        ack0_d  = ~gnt_q;
                        ack1_d  = gnt_q;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == LAST) begin
                    state_d = ACK;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end
            ACK: begin
                lock_d  = lock_in[gnt_q];
`ifdef LCD_ARB_ROUND_ROBIN_EN
                if (!lock_in[gnt_q]) ptr_d = ~gnt_q;
`else
                ptr_d   = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            start_q <= 1'b0;
            word_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            word_q  <= word_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign bus.oACK0      = ack0_q;
    assign bus.oACK1      = ack1_q;
    assign bus.oLCD_RS    = word_q[8];
    assign bus.oLCD_DATA  = word_q[7:0];
    assign bus.oLCD_START = start_q;
    assign bus.oGNT       = gnt_q;
    assign bus.oBUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter with a 3-cycle controller model.
// Tie ordering follows LCD_ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;
    localparam int DLY = 4;

    typedef struct packed {
        logic       gnt;
        logic [8:0] word;
    } exp_t;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;
    always #5 iCLK = ~iCLK;

    lcd_write_arbiter_if bus();

    lcd_write_arbiter #(
        .DLY_CYCLES(DLY),
        .DLY_W(18)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .bus(bus)
    );

    // Controller model: done pulses 3 cycles after start rises.
    logic       mdl_done;
    logic       stray;
    logic [1:0] ccnt;
    assign bus.iLCD_DONE = mdl_done | stray;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ccnt     <= 2'd0;
            mdl_done <= 1'b0;
        end else begin
            mdl_done <= 1'b0;
            if (bus.oLCD_START && !mdl_done) begin
                if (ccnt == 2'd2) begin
                    mdl_done <= 1'b1;
                    ccnt     <= 2'd0;
                end else begin
                    ccnt <= ccnt + 2'd1;
                end
            end else begin
                ccnt <= 2'd0;
            end
        end
    end

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop on each start rise, verify ack owner and latency.
    int   cyc = 0;
    int   done_cyc = 0;
    int   ack_cyc = 0;
    int   last_gap = 0;
    int   ack0_cnt = 0;
    int   ack1_cnt = 0;
    logic start_prev = 1'b0;
    logic cur_gnt = 1'b0;
    exp_t e;

    always @(negedge iCLK) begin
        cyc++;
        if (!iRST_N) begin
            start_prev = 1'b0;
        end else begin
            if (bus.oLCD_START && !start_prev) begin
                last_gap = cyc - ack_cyc;
                if (expq.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("grant", 32'(bus.oGNT), 32'(e.gnt));
                    chk("rs", 32'(bus.oLCD_RS), 32'(e.word[8]));
                    chk("data", 32'(bus.oLCD_DATA), 32'(e.word[7:0]));
                    chk("busy_at_start", 32'(bus.oBUSY), 1);
                    cur_gnt = e.gnt;
                end
            end
            if (bus.iLCD_DONE && bus.oLCD_START) done_cyc = cyc;
            if (bus.oACK0 || bus.oACK1) begin
                ack_cyc = cyc;
                if (bus.oACK0) ack0_cnt++;
                if (bus.oACK1) ack1_cnt++;
                chk("ack_onehot", 32'(bus.oACK0 & bus.oACK1), 0);
                chk("ack_owner", 32'(bus.oACK1), 32'(cur_gnt));
                chk("done_to_ack", 32'(cyc - done_cyc), DLY + 1);
                chk("busy_at_ack", 32'(bus.oBUSY), 1);
            end
            start_prev = bus.oLCD_START;
        end
    end

    task automatic set_port(input int p, input logic r, input logic [8:0] d, input logic l);
        if (p == 0) begin
            bus.iREQ0 = r; bus.iDATA0 = d; bus.iLOCK0 = l;
        end else begin
            bus.iREQ1 = r; bus.iDATA1 = d; bus.iLOCK1 = l;
        end
    endtask

    task automatic wait_ack(input int p);
        int t = 0;
        logic a;
        do begin
            @(negedge iCLK);
            t++;
            a = (p == 0) ? bus.oACK0 : bus.oACK1;
        end while (!a && t < 300);
        if (!a) chk($sformatf("ack_timeout_p%0d", p), 0, 1);
    endtask

    task automatic send_words(input int p, input logic [8:0] base, input int n, input logic lk);
        for (int i = 0; i < n; i++) begin
            set_port(p, 1'b1, base + 9'(i), lk);
            wait_ack(p);
        end
        set_port(p, 1'b0, 9'h000, 1'b0);
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        set_port(0, 1'b0, 9'h000, 1'b0);
        set_port(1, 1'b0, 9'h000, 1'b0);
        stray = 1'b0;
        expq.delete();
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((expq.size() != 0 || bus.oBUSY) && t < 500) begin
            @(negedge iCLK);
            t++;
        end
        chk(name, 32'(expq.size()), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.oLCD_START), 0);
        chk({tag, "_ack0"}, 32'(bus.oACK0), 0);
        chk({tag, "_ack1"}, 32'(bus.oACK1), 0);
        chk({tag, "_busy"}, 32'(bus.oBUSY), 0);
        chk({tag, "_gnt"}, 32'(bus.oGNT), 0);
        chk({tag, "_data"}, 32'(bus.oLCD_DATA), 0);
        chk({tag, "_rs"}, 32'(bus.oLCD_RS), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a0, a1, t;
        stray = 1'b0;
        set_port(0, 1'b0, 9'h000, 1'b0);
        set_port(1, 1'b0, 9'h000, 1'b0);
        repeat (2) @(negedge iCLK);
        chk_all_zero("reset");

        // Single word, then a back-to-back second word from requester 0.
        do_reset();
        a1 = ack1_cnt;
        expq.push_back('{gnt: 1'b0, word: 9'h141});
        expq.push_back('{gnt: 1'b0, word: 9'h142});
        set_port(0, 1'b1, 9'h141, 1'b0);
        @(posedge iCLK);
        #1;
        chk("start_latency", 32'(bus.oLCD_START), 1);
        chk("single_rs", 32'(bus.oLCD_RS), 1);
        chk("single_data", 32'(bus.oLCD_DATA), 32'h41);
        @(negedge iCLK);
        send_words(0, 9'h141, 2, 1'b0);
        drain("single_drain");
        chk("ack_to_start", 32'(last_gap), 2);
        chk("single_no_ack1", 32'(ack1_cnt - a1), 0);

        // Tie: both requesters hold 4 words each.
        do_reset();
`ifdef LCD_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            expq.push_back('{gnt: 1'b0, word: 9'h010 + 9'(i)});
            expq.push_back('{gnt: 1'b1, word: 9'h120 + 9'(i)});
        end
`else
        for (int i = 0; i < 4; i++) expq.push_back('{gnt: 1'b0, word: 9'h010 + 9'(i)});
        for (int i = 0; i < 4; i++) expq.push_back('{gnt: 1'b1, word: 9'h120 + 9'(i)});
`endif
        fork
            send_words(0, 9'h010, 4, 1'b0);
            send_words(1, 9'h120, 4, 1'b0);
        join
        drain("tie_drain");

        // Lock: requester 1 holds 17 locked words while requester 0 waits.
        do_reset();
        for (int i = 0; i < 17; i++) expq.push_back('{gnt: 1'b1, word: 9'h180 + 9'(i)});
        expq.push_back('{gnt: 1'b0, word: 9'h0C0});
        fork
            send_words(1, 9'h180, 17, 1'b1);
            begin
                repeat (2) @(negedge iCLK);
                send_words(0, 9'h0C0, 1, 1'b0);
            end
        join
        drain("lock_drain");

        // Reset during DELAY, then a pending request restarts.
        do_reset();
        expq.push_back('{gnt: 1'b0, word: 9'h055});
        set_port(0, 1'b1, 9'h055, 1'b0);
        t = 0;
        while (!bus.iLCD_DONE && t < 50) begin
            @(negedge iCLK);
            t++;
        end
        chk("midop_done_seen", 32'(bus.iLCD_DONE), 1);
        repeat (2) @(negedge iCLK);
        a0 = ack0_cnt;
        iRST_N = 1'b0;
        #1;
        chk("midop_rst_start", 32'(bus.oLCD_START), 0);
        chk("midop_rst_busy", 32'(bus.oBUSY), 0);
        @(negedge iCLK);
        chk_all_zero("midop");
        chk("midop_no_ack", 32'(ack0_cnt - a0), 0);
        expq.delete();
        expq.push_back('{gnt: 1'b0, word: 9'h055});
        iRST_N = 1'b1;
        wait_ack(0);
        set_port(0, 1'b0, 9'h000, 1'b0);
        drain("midop_drain");

        // Stray done while idle.
        a0 = ack0_cnt;
        a1 = ack1_cnt;
        @(negedge iCLK);
        stray = 1'b1;
        @(negedge iCLK);
        stray = 1'b0;
        repeat (DLY + 4) @(negedge iCLK);
        chk("stray_busy", 32'(bus.oBUSY), 0);
        chk("stray_start", 32'(bus.oLCD_START), 0);
        chk("stray_acks", 32'((ack0_cnt - a0) + (ack1_cnt - a1)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
